fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the opcode decoder. It holds the program counter and a word-addressed instruction memory that is loadable through a write port. It registers each fetched instruction into an IF/ID pipeline register, and the decoder takes its 6-bit opcode from that register. It resolves taken branches (beq with ALU zero) by redirecting the PC and flushing the wrong-path instruction.

Parameters:
ADDR_W, 8, word-address width of instruction memory
DEPTH, 256, number of 32-bit instruction words (2**ADDR_W)
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC and IF/ID register this cycle
branch  input  1  decoded beq in ID stage (from control)
zero  input  1  ALU zero flag for the branch compare
branch_offset  input  16  signed word offset (instr[15:0] of the branch)
imem_we  input  1  instruction-memory write enable
imem_waddr  input  ADDR_W  word address for the write
imem_wdata  input  32  instruction word to write
instr_out  output  32  IF/ID instruction register
opcode  output  6  instr_out[31:26], feeds the control decoder
pc_out  output  32  IF/ID copy of the fetched instruction's PC
pc_plus4  output  32  IF/ID copy of PC+4
valid  output  1  IF/ID holds a real (non-flushed) instruction
pc  output  32  current fetch PC

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, instr_out=0, pc_out=0, pc_plus4=0, valid=0. opcode=0, which decodes as R-format sll $0 (nop).
- Memory contents are not reset. Program loading is done with imem_we while stall=1.
- Fetch read is combinational: word = mem[pc[ADDR_W+1:2]]. pc[1:0] is ignored. The index wraps modulo DEPTH; PC bits above ADDR_W+1 are ignored for addressing.
- Memory write is synchronous on the rising edge. A same-cycle fetch of imem_waddr returns the old word; the new word is visible from the next cycle.
- taken = branch & zero & valid.
- target = pc_plus4 + (sign_extend32(branch_offset) << 2). pc_plus4 here is the IF/ID copy. Arithmetic is modulo 2^32.
- Per rising edge, priority order:
  1. taken: pc<=target; IF/ID flushed (instr_out<=0, valid<=0, pc_out and pc_plus4 <= 0). Flush overrides stall.
  2. stall (not taken): pc, instr_out, pc_out, pc_plus4 and valid all hold.
  3. otherwise: pc<=pc+4; instr_out<=fetched word; pc_out<=pc; pc_plus4<=pc+4; valid<=1.
- Latency: an instruction at PC appears on instr_out one cycle after pc equals that address.
- Branch penalty: exactly one flushed slot. The instruction after a taken branch is never marked valid.
- PC wrap: 32'hFFFF_FFFC+4 -> 0, and no error is flagged.
- An offset of -1 gives target = branch's own PC, so a tight loop is legal.
- Reset mid-operation: the next state is immediately the reset values. Any pending branch or stall is discarded. Memory retains its contents.
- imem_we is honoured independently of stall and branch.

Test Plan:
1. Reset, then load mem[0..3]=8C010004,AC010008,00221820,10000000 with stall=1, then release stall -> instr_out shows 8C010004,AC010008,00221820,10000000 on consecutive cycles with pc_out=0,4,8,C and valid=1. opcode 23 (lw) appears one cycle after pc=0.
2. Branch at pc_out=0x0C with pc_plus4=0x10, offset=16'hFFFC, branch=1, zero=1 -> pc<=0x00, next IF/ID has valid=0 and instr_out=0, then refetch proceeds from 0x00.
3. branch=1, zero=0 -> no redirect, pc keeps incrementing by 4 and no flush occurs. branch=1, zero=1 with valid=0 -> no redirect.
4. Hold stall=1 for 3 cycles mid-stream -> pc and all IF/ID outputs frozen. Stall together with a taken branch -> redirect and flush still occur.
5. Write mem[5] while pc=0x14 -> instr_out receives the old word that cycle. Stall one cycle, then refetch -> new word.
6. Drop rst_n between edges while valid=1 with pc=0x20 -> outputs go to reset values immediately and fetch restarts at RESET_PC with program memory intact. pc=0xFFFFFFFC -> next pc=0 with fetch index 0.

Source files
------------

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage that feeds the opcode decoder. It holds the program
// counter and a word-addressed instruction memory that can be loaded through a
// write port. Each fetched word is registered into the IF/ID pipeline
// register. A taken beq redirects the PC and flushes the wrong-path slot.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset (memory contents are kept)
//   stall          hold PC and IF/ID this cycle (a taken branch overrides it)
//   branch, zero   beq decoded in ID and the ALU zero flag
//   branch_offset  signed word offset of the branch
//   imem_we/waddr/wdata  synchronous instruction-memory write port
//   instr_out      IF/ID instruction register
//   opcode         instr_out[31:26], goes to the control decoder
//   pc_out         IF/ID copy of the fetched instruction's PC
//   pc_plus4       IF/ID copy of PC+4
//   valid          IF/ID holds a real (non-flushed) instruction
//   pc             current fetch PC
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 256,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    input  logic [15:0]       branch_offset,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    output logic [31:0]       instr_out,
    output logic [5:0]        opcode,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc_plus4,
    output logic              valid,
    output logic [31:0]       pc
);

    logic [31:0] mem_q [DEPTH];

    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] pc_out_q,   pc_out_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q,    valid_d;

    logic [ADDR_W-1:0] fetch_idx;
    logic [31:0]       fetch_word;
    logic [31:0]       offset_bytes;
    logic [31:0]       target;
    logic              taken;

    // Word index: the byte-offset bits are dropped and upper PC bits are
    // ignored, so the fetch address wraps modulo the memory depth.
    assign fetch_idx  = pc_q[ADDR_W+1:2];
    assign fetch_word = mem_q[fetch_idx];

    // Only a branch that is itself a valid instruction may redirect; this is
    // what makes the slot behind a taken branch unable to branch again.
    assign taken        = branch & zero & valid_q;
    assign offset_bytes = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign target       = pc_plus4_q + offset_bytes;

    // Memory write is not reset and is independent of stall/branch. The
    // combinational read above sees the old word during the write cycle.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem_q[imem_waddr] <= imem_wdata;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (taken) begin
            // Flush wins over stall: the wrong-path slot becomes a nop.
            pc_d       = target;
            instr_d    = 32'h0;
            pc_out_d   = 32'h0;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
        end else if (!stall) begin
            pc_d       = pc_q + 32'd4;
            instr_d    = fetch_word;
            pc_out_d   = pc_q;
            pc_plus4_d = pc_q + 32'd4;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            pc_out_q   <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign pc        = pc_q;
    assign instr_out = instr_q;
    assign opcode    = instr_q[31:26];
    assign pc_out    = pc_out_q;
    assign pc_plus4  = pc_plus4_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] OLD5   = 32'hDEAD_0005;
    localparam logic [31:0] NEW5   = 32'hBEEF_0505;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic [15:0] branch_offset = 16'h0;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = 8'h0;
    logic [31:0] imem_wdata = 32'h0;
    logic [31:0] instr_out;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        valid;
    logic [31:0] pc;

    int errors = 0;
    int checks = 0;

    fetch_stage #(.ADDR_W(8), .DEPTH(256), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .zero(zero),
        .branch_offset(branch_offset), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .instr_out(instr_out), .opcode(opcode),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .valid(valid), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_mem [256];
    logic [31:0] m_pc = RST_PC, m_instr = 0, m_pcout = 0, m_pcp4 = 0, m_word;
    logic        m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = RST_PC; m_instr = 0; m_pcout = 0; m_pcp4 = 0; m_valid = 0;
        end else begin
            m_word = m_mem[m_pc[9:2]];           // read before this edge's write
            if (imem_we) m_mem[imem_waddr] = imem_wdata;
            if (branch && zero && m_valid) begin
                m_pc = m_pcp4 + 32'(4 * $signed(branch_offset));
                m_instr = 0; m_pcout = 0; m_pcp4 = 0; m_valid = 0;
            end else if (!stall) begin
                m_instr = m_word; m_pcout = m_pc; m_pcp4 = m_pc + 4;
                m_pc = m_pc + 4; m_valid = 1;
            end
        end
    end

    // Compare process: every falling clock edge, all outputs vs the model.
    always @(negedge clk) begin
        check("pc", pc, m_pc);
        check("instr_out", instr_out, m_instr);
        check("opcode", {26'h0, opcode}, {26'h0, m_instr[31:26]});
        check("pc_out", pc_out, m_pcout);
        check("pc_plus4", pc_plus4, m_pcp4);
        check("valid", {31'h0, valid}, {31'h0, m_valid});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h8C010004; prog[1] = 32'hAC010008;
        prog[2] = 32'h00221820; prog[3] = 32'h10000000;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_pc", pc, RST_PC);
        check("rst_instr", instr_out, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_opcode", {26'h0, opcode}, 32'h0);
        #9 rst_n = 1'b1;

        // Load whole memory under stall
        stall = 1'b1;
        for (int i = 0; i < 256; i++) begin
            imem_we = 1'b1; imem_waddr = 8'(i);
            imem_wdata = (i < 4) ? prog[i] : (i == 5) ? OLD5 : $urandom;
            tick();
            check("load_pc_hold", pc, RST_PC);
        end
        imem_we = 1'b0;

        // 1: straight-line fetch
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_instr", instr_out, prog[i]);
            check("t1_pc_out", pc_out, 32'(4 * i));
            check("t1_valid", {31'h0, valid}, 32'h1);
            if (i == 0) check("t1_opcode_lw", {26'h0, opcode}, 32'h23);
        end
        // 2: taken branch from 0x0C back to 0x00
        check("t2_pc_plus4", pc_plus4, 32'h10);
        branch = 1'b1; zero = 1'b1; branch_offset = 16'hFFFC;
        tick();
        check("t2_pc", pc, 32'h0);
        check("t2_flush_valid", {31'h0, valid}, 32'h0);
        check("t2_flush_instr", instr_out, 32'h0);
        branch = 1'b0;
        tick();
        check("t2_refetch", instr_out, prog[0]);
        // 3: not-taken, and branch ignored in a flushed slot
        branch = 1'b1; zero = 1'b0;
        tick();
        check("t3_nt_pc", pc, 32'h8);
        check("t3_nt_valid", {31'h0, valid}, 32'h1);
        zero = 1'b1; branch_offset = 16'h0;
        tick();
        check("t3_self_pc", pc, 32'h8);
        tick();
        check("t3_noval_pc", pc, 32'hC);
        check("t3_noval_valid", {31'h0, valid}, 32'h1);
        branch = 1'b0;
        // 4: stall freeze, then stall + taken branch
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_stall_pc", pc, 32'hC);
            check("t4_stall_pc_out", pc_out, 32'h8);
            check("t4_stall_instr", instr_out, prog[2]);
        end
        branch = 1'b1; zero = 1'b1; branch_offset = 16'h0001;
        tick();
        check("t4_stallbr_pc", pc, 32'h10);
        check("t4_stallbr_valid", {31'h0, valid}, 32'h0);
        branch = 1'b0; stall = 1'b0;
        // 5: write-during-fetch returns old word
        tick();
        check("t5_pc", pc, 32'h14);
        imem_we = 1'b1; imem_waddr = 8'd5; imem_wdata = NEW5;
        tick();
        check("t5_old_word", instr_out, OLD5);
        imem_we = 1'b0; stall = 1'b1;
        tick();
        stall = 1'b0; branch = 1'b1; zero = 1'b1; branch_offset = 16'hFFFF;
        tick();
        check("t5_loop_pc", pc, 32'h14);
        branch = 1'b0;
        tick();
        check("t5_new_word", instr_out, NEW5);
        // 6: async reset mid-cycle, then PC wrap
        tick(); tick();
        check("t6_pre_pc", pc, 32'h20);
        check("t6_pre_valid", {31'h0, valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_pc", pc, RST_PC);
        check("t6_rst_valid", {31'h0, valid}, 32'h0);
        check("t6_rst_instr", instr_out, 32'h0);
        #2 rst_n = 1'b1;
        tick();
        check("t6_mem_kept", instr_out, prog[0]);
        branch = 1'b1; zero = 1'b1; branch_offset = 16'hFFFE;
        tick();
        check("t6_wrap_target", pc, 32'hFFFF_FFFC);
        branch = 1'b0;
        tick();
        check("t6_wrap_pc", pc, 32'h0);
        tick();
        check("t6_wrap_fetch0", instr_out, prog[0]);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            stall = ($urandom_range(3) == 0);
            branch = ($urandom_range(2) == 0);
            zero = 1'($urandom_range(1));
            branch_offset = 16'($urandom);
            imem_we = ($urandom_range(7) == 0);
            imem_waddr = 8'($urandom);
            imem_wdata = $urandom;
            if ($urandom_range(63) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end

        #10;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
